// File: rtl/bme_regs_pkg.sv
// Register map constants and FSM state type shared by the BME280-style SPI
// responder. Optional build macro: SOFT_RESET_EN (enables 0xE0 soft reset).
package bme_regs_pkg;

    localparam logic [7:0] ADDR_DIG_T1_LSB = 8'h88;
    localparam logic [7:0] ADDR_DIG_T1_MSB = 8'h89;
    localparam logic [7:0] ADDR_DIG_T2_LSB = 8'h8A;
    localparam logic [7:0] ADDR_DIG_T2_MSB = 8'h8B;
    localparam logic [7:0] ADDR_DIG_T3_LSB = 8'h8C;
    localparam logic [7:0] ADDR_DIG_T3_MSB = 8'h8D;
    localparam logic [7:0] ADDR_CHIP_ID    = 8'hD0;
    localparam logic [7:0] ADDR_RESET      = 8'hE0;
    localparam logic [7:0] ADDR_CTRL_MEAS  = 8'hF4;
    localparam logic [7:0] ADDR_CONFIG     = 8'hF5;
    localparam logic [7:0] ADDR_TEMP_MSB   = 8'hFA;
    localparam logic [7:0] ADDR_TEMP_LSB   = 8'hFB;
    localparam logic [7:0] ADDR_TEMP_XLSB  = 8'hFC;

    localparam logic [7:0] SOFT_RESET_KEY  = 8'hB6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RDATA,
        ST_WDATA
    } bme_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchroniser for one SPI pin with optional rise/fall detection.
// The edge detector compares the synchroniser output with a delayed copy.
module spi_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          EDGE_DET    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw pin into the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    // Chain resets low so an already-low pin never produces a fake edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign dout = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_DET) begin : g_edge
            logic last_q;
            logic last_d;

            // Previous synchronised level for edge comparison.
            always_comb begin
                last_d = dout;
            end

            // Delayed copy of the synchronised level.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) last_q <= 1'b0;
                else     last_q <= last_d;
            end

            assign rise = dout & ~last_q;
            assign fall = ~dout & last_q;
        end else begin : g_no_edge
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/bme_spi_responder.sv
// SPI mode-0 responder emulating the temperature register map of a
// BME280-class sensor. Optional build macro: SOFT_RESET_EN, which makes
// address 0xE0 accept the soft-reset key and clear ctrl_meas/config.
module bme_spi_responder
    import bme_regs_pkg::*;
#(
    parameter logic [7:0]  CHIP_ID     = 8'h60,
    parameter logic [15:0] DIG_T1      = 16'd27504,
    parameter logic [15:0] DIG_T2      = 16'd26435,
    parameter logic [15:0] DIG_T3      = 16'hFC18,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        SCK,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    output logic        miso_oe,
    input  logic [19:0] adc_temp,
    output logic [7:0]  ctrl_meas,
    output logic [7:0]  config_reg,
    output logic        wr_strobe,
    output logic        busy
);

    logic sck_rise, sck_fall, sck_level_unused;
    logic cs_rise, cs_fall, cs_level_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sck_sync (
        .clk  (clk),
        .rst  (RESET),
        .din  (SCK),
        .dout (sck_level_unused),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (RESET),
        .din  (CS),
        .dout (cs_level_unused),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_mosi_sync (
        .clk  (clk),
        .rst  (RESET),
        .din  (MOSI),
        .dout (mosi_s),
        .rise (mosi_rise_unused),
        .fall (mosi_fall_unused)
    );

    bme_state_e  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  tx_q, tx_d;
    logic [19:0] snap_q, snap_d;
    logic        miso_q, miso_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        strobe_q, strobe_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  cfg_q, cfg_d;

    logic [7:0]  rx_byte;
    logic [7:0]  rd_byte;

    // Read mux: register contents at the current pointer.
    always_comb begin
        rd_byte = '0;
        case (ptr_q)
            ADDR_DIG_T1_LSB: rd_byte = DIG_T1[7:0];
            ADDR_DIG_T1_MSB: rd_byte = DIG_T1[15:8];
            ADDR_DIG_T2_LSB: rd_byte = DIG_T2[7:0];
            ADDR_DIG_T2_MSB: rd_byte = DIG_T2[15:8];
            ADDR_DIG_T3_LSB: rd_byte = DIG_T3[7:0];
            ADDR_DIG_T3_MSB: rd_byte = DIG_T3[15:8];
            ADDR_CHIP_ID:    rd_byte = CHIP_ID;
            ADDR_CTRL_MEAS:  rd_byte = ctrl_q;
            ADDR_CONFIG:     rd_byte = cfg_q;
            ADDR_TEMP_MSB:   rd_byte = snap_q[19:12];
            ADDR_TEMP_LSB:   rd_byte = snap_q[11:4];
            ADDR_TEMP_XLSB:  rd_byte = {snap_q[3:0], 4'b0000};
            default:         rd_byte = '0;
        endcase
    end

    // Next-state logic: frame sequencing, shifting and register writes.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        tx_d      = tx_q;
        snap_d    = snap_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        strobe_d  = 1'b0;
        ctrl_d    = ctrl_q;
        cfg_d     = cfg_q;
        rx_byte   = {shift_q[6:0], mosi_s};

        // CS rise has priority over any coincident SCK edge.
        if (cs_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d   = ST_ADDR;
                        snap_d    = adc_temp;
                        bit_cnt_d = '0;
                        busy_d    = 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7]) begin
                                ptr_d   = rx_byte;
                                state_d = ST_RDATA;
                                oe_d    = 1'b1;
                            end else begin
                                ptr_d   = {1'b1, rx_byte[6:0]};
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end
                // bit_cnt counts data bits sent; count 0 marks a byte load.
                ST_RDATA: begin
                    if (sck_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            miso_d = rd_byte[7];
                            tx_d   = {rd_byte[6:0], 1'b0};
                        end else begin
                            miso_d = tx_q[7];
                            tx_d   = {tx_q[6:0], 1'b0};
                        end
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ptr_d = ptr_q + 8'd1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (sck_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_ADDR;
                            case (ptr_q)
                                ADDR_CTRL_MEAS: begin
                                    ctrl_d   = rx_byte;
                                    strobe_d = 1'b1;
                                end
                                ADDR_CONFIG: begin
                                    cfg_d    = rx_byte;
                                    strobe_d = 1'b1;
                                end
`ifdef SOFT_RESET_EN
                                ADDR_RESET: begin
                                    if (rx_byte == SOFT_RESET_KEY) begin
                                        ctrl_d   = '0;
                                        cfg_d    = '0;
                                        strobe_d = 1'b1;
                                    end
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            tx_q      <= '0;
            snap_q    <= '0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            strobe_q  <= 1'b0;
            ctrl_q    <= '0;
            cfg_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            tx_q      <= tx_d;
            snap_q    <= snap_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            strobe_q  <= strobe_d;
            ctrl_q    <= ctrl_d;
            cfg_q     <= cfg_d;
        end
    end

    assign MISO       = miso_q;
    assign miso_oe    = oe_q;
    assign busy       = busy_q;
    assign wr_strobe  = strobe_q;
    assign ctrl_meas  = ctrl_q;
    assign config_reg = cfg_q;

endmodule

// File: tb/tb_bme_spi_responder.sv
// Directed bench for bme_spi_responder: acts as an SPI mode-0 master with
// SCK at clk/16 and checks results against hand-computed register values.
`timescale 1ns/1ps
module tb_bme_spi_responder;

    localparam int HALF = 80;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        SCK = 1'b0;
    logic        CS = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic        miso_oe;
    logic [19:0] adc_temp = '0;
    logic [7:0]  ctrl_meas;
    logic [7:0]  config_reg;
    logic        wr_strobe;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int oe_hits = 0;

    bme_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .RESET      (RESET),
        .SCK        (SCK),
        .CS         (CS),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .miso_oe    (miso_oe),
        .adc_temp   (adc_temp),
        .ctrl_meas  (ctrl_meas),
        .config_reg (config_reg),
        .wr_strobe  (wr_strobe),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) strobe_cnt++;
        if (miso_oe)   oe_hits++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            MOSI = tx[7-i];
            #HALF;
            rx[7-i] = MISO;
            SCK = 1'b1;
            #HALF;
            SCK = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        xfer_bits(tx, 8, rx);
    endtask

    task automatic cs_low();
        CS = 1'b0;
        #HALF;
    endtask

    task automatic cs_high();
        #HALF;
        CS = 1'b1;
        MOSI = 1'b0;
        #(HALF * 2);
    endtask

    initial begin
        logic [7:0] rx;
        int s0;
        int o0;

        // Reset state
        #23;
        check("rst_miso", MISO, 1'b0);
        check("rst_oe", miso_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_strobe", wr_strobe, 1'b0);
        check("rst_ctrl", ctrl_meas, 8'h00);
        check("rst_config", config_reg, 8'h00);
        RESET = 1'b0;
        #(HALF * 2);

        // Two address/data write pairs in one frame
        s0 = strobe_cnt;
        o0 = oe_hits;
        cs_low();
        xfer(8'h74, rx);
        check("wr_busy", busy, 1'b1);
        xfer(8'hA3, rx);
        xfer(8'h75, rx);
        xfer(8'h84, rx);
        cs_high();
        check("wr_ctrl", ctrl_meas, 8'hA3);
        check("wr_config", config_reg, 8'h84);
        check("wr_strobes", strobe_cnt - s0, 2);
        check("wr_oe_quiet", oe_hits - o0, 0);
        check("wr_busy_end", busy, 1'b0);

        // Temperature burst read with adc_temp changed mid-frame
        adc_temp = 20'h6A3C5;
        cs_low();
        xfer(8'hFA, rx);
        check("rd_oe", miso_oe, 1'b1);
        xfer(8'h00, rx);
        check("temp_msb", rx, 8'h6A);
        adc_temp = 20'hFFFFF;
        xfer(8'h00, rx);
        check("temp_lsb", rx, 8'h3C);
        xfer(8'h00, rx);
        check("temp_xlsb", rx, 8'h50);
        cs_high();
        check("rd_oe_end", miso_oe, 1'b0);
        check("rd_miso_end", MISO, 1'b0);

        // New frame sees the new snapshot
        cs_low();
        xfer(8'hFA, rx);
        xfer(8'h00, rx);
        check("temp_new", rx, 8'hFF);
        cs_high();

        // Trim word burst, little-endian
        cs_low();
        xfer(8'h88, rx);
        xfer(8'h00, rx); check("t1_lsb", rx, 8'h70);
        xfer(8'h00, rx); check("t1_msb", rx, 8'h6B);
        xfer(8'h00, rx); check("t2_lsb", rx, 8'h43);
        xfer(8'h00, rx); check("t2_msb", rx, 8'h67);
        xfer(8'h00, rx); check("t3_lsb", rx, 8'h18);
        xfer(8'h00, rx); check("t3_msb", rx, 8'hFC);
        cs_high();

        // Partial write byte is discarded
        s0 = strobe_cnt;
        cs_low();
        xfer(8'h74, rx);
        xfer_bits(8'h55, 5, rx);
        cs_high();
        check("part_ctrl", ctrl_meas, 8'hA3);
        check("part_strobe", strobe_cnt - s0, 0);
        check("part_busy", busy, 1'b0);

        // Pointer wraps 0xFF -> 0x00
        cs_low();
        xfer(8'hFF, rx);
        xfer(8'h00, rx); check("wrap_ff", rx, 8'h00);
        xfer(8'h00, rx); check("wrap_00", rx, 8'h00);
        cs_high();

        // Readback of chip ID and configuration registers
        cs_low();
        xfer(8'hF4, rx);
        xfer(8'h00, rx); check("rd_ctrl", rx, 8'hA3);
        xfer(8'h00, rx); check("rd_config", rx, 8'h84);
        cs_high();
        cs_low();
        xfer(8'hD0, rx);
        xfer(8'h00, rx); check("chip_id", rx, 8'h60);
        cs_high();

        // Soft reset key at 0xE0
        s0 = strobe_cnt;
        cs_low();
        xfer(8'h60, rx);
        xfer(8'hB6, rx);
        check("sr_busy", busy, 1'b1);
        cs_high();
`ifdef SOFT_RESET_EN
        check("sr_ctrl", ctrl_meas, 8'h00);
        check("sr_config", config_reg, 8'h00);
        check("sr_strobe", strobe_cnt - s0, 1);
`else
        check("sr_ctrl", ctrl_meas, 8'hA3);
        check("sr_config", config_reg, 8'h84);
        check("sr_strobe", strobe_cnt - s0, 0);
`endif

        // RESET in the middle of a chip ID read (0x60: second bit is 1)
        cs_low();
        xfer(8'hD0, rx);
        xfer_bits(8'h00, 1, rx);
        #HALF;
        check("mid_miso", MISO, 1'b1);
        check("mid_oe", miso_oe, 1'b1);
        #3;
        RESET = 1'b1;
        #1;
        check("rst_mid_miso", MISO, 1'b0);
        check("rst_mid_oe", miso_oe, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        #20;
        RESET = 1'b0;
        // CS still low: more clocks must not start a frame
        xfer(8'hD0, rx);
        xfer(8'h00, rx);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_oe", miso_oe, 1'b0);
        cs_high();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bme_spi_responder.md
Name: bme_spi_responder

Overview:
SPI mode-0 responder that emulates the temperature register map of a BME280-class sensor on the FPGA. It is the far end of the on-board SPI master. It oversamples SCK, CS and MOSI in the system clock domain, decodes address/data bytes and serves reads from a register map:
- chip ID
- trim words
- configuration registers
- snapshotted 20-bit ADC temperature

It serves as an in-fabric sensor stand-in for loopback bring-up and regression of the sensor-reading path.

Parameters:
CHIP_ID, 8'h60, value returned at address 0xD0
DIG_T1, 16'd27504, unsigned trim word at 0x88 (LSB) / 0x89 (MSB)
DIG_T2, 16'd26435, trim word at 0x8A / 0x8B
DIG_T3, 16'hFC18, trim word at 0x8C / 0x8D
SYNC_STAGES, 2, flip-flop depth of the SCK/CS/MOSI synchronisers (min 2)

Ports:
clk  input  1  system clock; SCK frequency must be no more than clk/8
RESET  input  1  asynchronous active-high reset
SCK  input  1  SPI clock from the master, idle low
CS  input  1  chip select, active low
MOSI  input  1  serial data from the master
MISO  output  1  serial data to the master
miso_oe  output  1  MISO drive enable, high only while a read is in progress
adc_temp  input  20  live temperature ADC value
ctrl_meas  output  8  register 0xF4
config  output  8  register 0xF5
wr_strobe  output  1  one-cycle pulse when 0xF4 or 0xF5 is written
busy  output  1  high while CS is low (synchronised)

Behaviour:
- Reset values:
  - MISO=0, miso_oe=0, busy=0, wr_strobe=0
  - ctrl_meas=8'h00, config=8'h00
  - state=IDLE, bit counter=0, temperature snapshot=0
- Input conditioning and edge detection:
  - SCK, CS and MOSI each pass through SYNC_STAGES flops.
  - Edges are detected on the last two stages.
  - Pin-to-action latency is SYNC_STAGES+1 clk.
- States: IDLE, ADDR, RDATA, WDATA.
  - IDLE -> ADDR on synchronised CS fall. On that cycle, adc_temp is latched into the snapshot, bit counter is cleared, and busy rises.
  - ADDR: MOSI is shifted in MSB first on each SCK rise. After the 8th rise the byte is decoded:
    - bit7=1: read; pointer = full byte; go to RDATA.
    - bit7=0: write; pointer = {1'b1, byte[6:0]}; go to WDATA.
  - RDATA:
    - miso_oe=1.
    - On the SCK fall following the 8th address rise, the byte at the pointer is loaded and its MSB is driven.
    - Each later SCK fall shifts the next bit out.
    - After each 8 data bits the pointer increments, wrapping 0xFF->0x00, and the next byte is loaded on the following fall.
  - WDATA:
    - After 8 rises, if pointer is 0xF4 or 0xF5, the register updates and wr_strobe pulses for 1 clk. Other addresses are silently ignored.
    - The machine then returns to ADDR, giving repeated address/data pairs.
  - Any state -> IDLE on synchronised CS rise: miso_oe=0, MISO=0, busy=0. A partial byte is discarded and never written.
- Read map:
  - 0x88-0x8D: DIG_T1..DIG_T3, little-endian.
  - 0xD0: CHIP_ID.
  - 0xF4: ctrl_meas. 0xF5: config.
  - 0xFA: snap[19:12]. 0xFB: snap[11:4]. 0xFC: {snap[3:0], 4'b0000}.
  - All other addresses: 8'h00.
- The snapshot is held for the whole CS-low frame. Changes to adc_temp mid-frame are invisible, so a burst read is coherent.
- MISO is 0 and miso_oe is 0 during ADDR and WDATA.
- Simultaneous CS rise and SCK edge in the same clk: CS wins; the edge is ignored.
- SCK edges while CS is high are ignored.
- RESET asserted mid-frame: immediate return to reset values. After RESET releases, the machine stays in IDLE until a fresh CS fall; an already-low CS is not treated as a new frame.

Optional Feature:
SOFT_RESET_EN
- Defined: address 0xE0 is writable. Writing 8'hB6 clears ctrl_meas and config to 8'h00 on the same cycle as a single wr_strobe pulse; the frame itself continues. Reading 0xE0 returns 8'h00.
- Undefined: 0xE0 behaves like any unmapped address (write ignored, reads 8'h00).

Decomposition:
- Shared package bme_regs_pkg holds:
  - address constants ADDR_DIG_T1_LSB..ADDR_DIG_T3_MSB, ADDR_CHIP_ID, ADDR_RESET, ADDR_CTRL_MEAS, ADDR_CONFIG, ADDR_TEMP_MSB/LSB/XLSB
  - constant SOFT_RESET_KEY=8'hB6
  - the state enum type
- One sub-module, spi_pin_sync: a parameterised SYNC_STAGES synchroniser plus rise/fall detector, instantiated for SCK and CS and used for MOSI without an edge detector.

Test Plan:
1. Write frame 0x74,0xA3 then 0x75,0x84 in one CS-low period -> ctrl_meas=8'hA3, config=8'h84, two wr_strobe pulses, miso_oe stays 0.
2. adc_temp=20'h6A3C5; burst read 0xFA for 3 bytes -> MISO yields 8'h6A, 8'h3C, 8'h50.
3. Burst read 0x88 for 6 bytes with default parameters -> 8'h70, 8'h6B, 8'h43, 8'h67, 8'h18, 8'hFC.
4. During test 2, change adc_temp to 20'hFFFFF after the first data byte -> the second and third bytes still read 8'h3C and 8'h50. A new frame then reads 0xFA as 8'hFF.
5. Raise CS after 5 bits of a write to 0xF4 -> ctrl_meas unchanged, no wr_strobe, IDLE. Read 0xFF with 2 bytes -> 8'h00 then 8'h00 from 0x00 (wrap).
6. Assert RESET mid-read of 0xD0 -> MISO=0 and miso_oe=0 the same cycle. With SOFT_RESET_EN defined, writing 0x60,0xB6 after setting ctrl_meas=8'hA3 -> ctrl_meas=8'h00.
